bram_dp: RTL and testbench
==========================

# bram_dp

Parametrised one-write/two-read behavioural block RAM, the next generation of the team's fixed 12-word, 32-bit simulation BRAM used as tap/data storage next to the FIR datapath. Port A is read/write with byte enables and byte addressing; port B is read-only, so the AXI-Lite side can read back coefficients while the datapath reads and writes data. Both read ports have registered outputs with fixed one-cycle latency. An optional post-reset clear engine zeroes every word before the RAM accepts traffic. Behavioural model only; not intended for synthesis.

## Interface
- DW, 32: data width in bits; multiple of 8.
- DEPTH, 12: number of words.
- AW, 12: byte-address width.
- RDW_B, 0: port-B read of a word port A writes in the same cycle; 0 = old data, 1 = new (merged) data.
- CLK  in  1  clock; all activity on rising edge.
- RST  in  1  synchronous, active-high reset.
- EN_A  in  1  port-A enable.
- WE_A  in  DW/8  port-A byte write enables; bit i covers Di_A[8i+7:8i].
- A_A  in  AW  port-A byte address.
- Di_A  in  DW  port-A write data.
- Do_A  out  DW  port-A read data, registered.
- EN_B  in  1  port-B read enable.
- A_B  in  AW  port-B byte address.
- Do_B  out  DW  port-B read data, registered.
- BUSY  out  1  clear engine active; ports ignored while high.

## Operation
- Word index = A >> log2(DW/8); low address bits are ignored.
- Index >= DEPTH is out of range: writes are dropped and reads return 0.
- Write: EN_A=1 and WE_A bit i=1 updates byte i of the addressed word at the edge. Bytes with WE_A=0 are unchanged.
- Read A: EN_A=1 loads Do_A with the word at the edge, regardless of WE_A. The port is write-first: Do_A shows the merged post-write word.
- Read B: EN_B=1 loads Do_B. On a same-word collision with a port-A write, Do_B gets the pre-write word (RDW_B=0) or the merged word (RDW_B=1).
- EN low on a port: its Do holds its last value.
- Reset: Do_A=0, Do_B=0, BUSY=1 (clear engine compiled in) or BUSY=0 (compiled out). RAM contents are not touched by RST itself.
- Clear FSM states:
  - CLEAR: counter held at 0 while RST=1. After RST falls, one word is zeroed per cycle, indices 0..DEPTH-1.
  - IDLE: entered after index DEPTH-1 is written; BUSY=0.
- While BUSY=1: all port writes are dropped, EN_A/EN_B are ignored, and Do_A/Do_B hold 0.
- RST asserted mid-clear returns the counter to 0 and restarts the full sweep.

## Timing
- Read latency: 1 cycle. Address and enable at edge N give data on Do from edge N onward, stable for cycle N+1.
- A write at edge N is visible to any read sampled at edge N+1 or later.
- BUSY stays high during RST and for exactly DEPTH cycles after RST deasserts.
  - BUSY falls at the edge that writes word DEPTH-1.
  - The first accepted port access is at the edge following BUSY=0.
- Counter width: ceil(log2(DEPTH)); must not wrap before DEPTH-1.

## Configuration
- BRAM_DP_CLEAR_EN defined:
  - Clear FSM and counter are present; BUSY behaves as above.
  - Memory reads 0 after the clear completes.
- BRAM_DP_CLEAR_EN undefined:
  - No FSM; BUSY is tied 0.
  - RAM initial contents are X; ports are usable on the first cycle after RST falls.
  - RST only clears Do_A and Do_B.

## Test plan
- Clear (macro on, DEPTH=12): RST high 3 cycles, then low → BUSY=1 for 12 cycles after release. Afterwards, port-B reads of addresses 0x00..0x2C all return 0x00000000.
- Byte enables:
  - Write 0xAABBCCDD to 0x08 with WE_A=4'hF, then 0x11223344 with WE_A=4'b0101 → read gives 0xAA22CC44.
  - Write to address 0x0B → same word as 0x08.
- Collision: word 0x10 holds 0x1; port A writes 0x2 to 0x10 while port B reads 0x10 in the same cycle → Do_A=0x2; Do_B=0x1 (RDW_B=0) or 0x2 (RDW_B=1).
- Out of range: write 0xDEAD to 0x30 (index 12) → no word changes; a read of 0x30 returns 0.
- Reset mid-clear: assert RST at clear cycle 5 for 1 cycle → BUSY stays high 12 further cycles; words 0..4, previously written 0x5A, read 0 afterwards.
- Hold and busy drop:
  - EN_B low for 4 cycles after a read of 0x7 → Do_B stays 0x7.
  - Write attempted while BUSY=1 → dropped; later read returns 0.

Source files
------------

// File: rtl/bram_dp.sv
// bram_dp: one-write/two-read block RAM with byte-enabled port A, read-only port B and registered outputs.
// Defining BRAM_DP_CLEAR_EN adds a post-reset engine that zeroes every word before traffic is accepted.
module bram_dp #(
    parameter int DW    = 32,
    parameter int DEPTH = 12,
    parameter int AW    = 12,
    parameter int RDW_B = 0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EN_A,
    input  logic [DW/8-1:0] WE_A,
    input  logic [AW-1:0]   A_A,
    input  logic [DW-1:0]   Di_A,
    output logic [DW-1:0]   Do_A,
    input  logic            EN_B,
    input  logic [AW-1:0]   A_B,
    output logic [DW-1:0]   Do_B,
    output logic            BUSY
);
    localparam int BPW = DW / 8;
    localparam int OFF = (BPW > 1) ? $clog2(BPW) : 0;
    localparam int CW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0]  old_w,
                                                  input logic [DW-1:0]  new_w,
                                                  input logic [BPW-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < BPW; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] a_idx, b_idx;
    logic          a_hit, b_hit;
    logic [CW-1:0] a_word, b_word;
    logic [DW-1:0] a_old, a_new, b_old, b_rd;
    logic          busy;
    logic          a_wr;
    logic          clr_wr;
    logic [CW-1:0] clr_idx;
    logic [DW-1:0] do_a_q, do_a_d, do_b_q, do_b_d;

    // Address decode and port-A write-first merge
    always_comb begin
        a_idx  = A_A >> OFF;
        b_idx  = A_B >> OFF;
        a_hit  = a_idx < DEPTH_A;
        b_hit  = b_idx < DEPTH_A;
        a_word = a_hit ? a_idx[CW-1:0] : '0;
        b_word = b_hit ? b_idx[CW-1:0] : '0;
        a_old  = mem[a_word];
        a_new  = merge_bytes(a_old, Di_A, WE_A);
        b_old  = b_hit ? mem[b_word] : '0;
        // Same-word collision: optionally forward the merged port-A word to port B
        b_rd   = ((RDW_B != 0) && EN_A && a_hit && (a_idx == b_idx)) ? a_new : b_old;
        a_wr   = !RST && !busy && EN_A && a_hit;
    end

    always_comb begin
        do_a_d = do_a_q;
        do_b_d = do_b_q;
        if (busy) begin
            do_a_d = '0;
            do_b_d = '0;
        end else begin
            if (EN_A) do_a_d = a_hit ? a_new : '0;
            if (EN_B) do_b_d = b_rd;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            do_a_q <= '0;
            do_b_q <= '0;
        end else begin
            do_a_q <= do_a_d;
            do_b_q <= do_b_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (clr_wr) begin
            mem[clr_idx] <= '0;
        end else if (a_wr) begin
            mem[a_word] <= a_new;
        end
    end

`ifdef BRAM_DP_CLEAR_EN
    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // One word zeroed per cycle; leaving CLEAR coincides with the write of the last word
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_wr  = 1'b0;
        if (state_q == S_CLEAR && !RST) begin
            clr_wr = 1'b1;
            if (cnt_q == CW'(DEPTH - 1)) state_d = S_IDLE;
            else                         cnt_d   = cnt_q + CW'(1);
        end
    end

    assign busy    = (state_q == S_CLEAR);
    assign clr_idx = cnt_q;
`else
    assign busy    = 1'b0;
    assign clr_wr  = 1'b0;
    assign clr_idx = '0;
`endif

    assign Do_A = do_a_q;
    assign Do_B = do_b_q;
    assign BUSY = busy;

endmodule

// File: tb/tb_bram_dp.sv
// Self-checking bench for bram_dp: directed vector table, clear/reset sequences and random traffic
// compared against a word-array reference model.
module tb_bram_dp;
    localparam int DW    = 32;
    localparam int DEPTH = 12;
    localparam int AW    = 12;
    localparam int RDW_B = 0;
`ifdef BRAM_DP_CLEAR_EN
    localparam int CLR = 1;
`else
    localparam int CLR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, en_a, en_b;
    logic [3:0]  we_a;
    logic [11:0] a_a, a_b;
    logic [31:0] di_a;
    logic [31:0] do_a, do_b;
    logic        busy;

    bram_dp #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .RDW_B(RDW_B)) dut (
        .CLK(clk), .RST(rst), .EN_A(en_a), .WE_A(we_a), .A_A(a_a), .Di_A(di_a), .Do_A(do_a),
        .EN_B(en_b), .A_B(a_b), .Do_B(do_b), .BUSY(busy)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] ref_mem [int];
    logic [31:0] exp_a = 0, exp_b = 0;
    logic        exp_busy = 0;
    int          clr_left = 0;

    typedef struct {
        logic        en_a;
        logic [3:0]  we;
        logic [11:0] a_a;
        logic [31:0] di;
        logic        en_b;
        logic [11:0] a_b;
        logic [31:0] xa;
        logic [31:0] xb;
    } vec_t;
    vec_t tbl [$];

    task automatic add_vec(input logic ea, input logic [3:0] we, input logic [11:0] aa,
                           input logic [31:0] di, input logic eb, input logic [11:0] ab,
                           input logic [31:0] xa, input logic [31:0] xb);
        vec_t v;
        v.en_a = ea; v.we = we; v.a_a = aa; v.di = di;
        v.en_b = eb; v.a_b = ab; v.xa = xa; v.xb = xb;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: words addressed as byte_address/4, out-of-range indices never stored
    task automatic model_edge();
        int          ia, ib;
        logic [31:0] old_b, w;
        if (rst) begin
            exp_a = 0; exp_b = 0;
            clr_left = (CLR != 0) ? DEPTH : 0;
        end else if (clr_left > 0) begin
            ref_mem[DEPTH - clr_left] = 0;
            clr_left--;
            exp_a = 0; exp_b = 0;
        end else begin
            ia = int'(a_a) / 4;
            ib = int'(a_b) / 4;
            old_b = (ib < DEPTH) ? ref_mem[ib] : 32'h0;
            if (en_a) begin
                if (ia < DEPTH) begin
                    w = ref_mem[ia];
                    for (int i = 0; i < 4; i++)
                        if (we_a[i]) w = (w & ~(32'hFF << (8 * i))) | (di_a & (32'hFF << (8 * i)));
                    ref_mem[ia] = w;
                    exp_a = w;
                end else begin
                    exp_a = 0;
                end
            end
            if (en_b) begin
                if (ib >= DEPTH)                              exp_b = 0;
                else if (RDW_B != 0 && en_a && ia == ib)      exp_b = ref_mem[ib];
                else                                          exp_b = old_b;
            end
        end
        exp_busy = (clr_left > 0);
    endtask

    task automatic step(input string nm);
        model_edge();
        @(posedge clk);
        #1;
        chk({nm, "_DoA"}, do_a, exp_a);
        chk({nm, "_DoB"}, do_b, exp_b);
        chk({nm, "_BUSY"}, {31'b0, busy}, {31'b0, exp_busy});
    endtask

    task automatic idle_ports();
        en_a = 0; we_a = 0; a_a = 0; di_a = 0; en_b = 0; a_b = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1;
        idle_ports();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 0;
        for (int i = 0; i < 3; i++) step("reset");
        chk("reset_DoA_zero", do_a, 32'h0);
        chk("reset_DoB_zero", do_b, 32'h0);
        rst = 0;
`ifdef BRAM_DP_CLEAR_EN
        // Port-A write held during the whole sweep must be dropped, including at the falling edge of BUSY
        en_a = 1; we_a = 4'hF; a_a = 12'h02C; di_a = 32'h0000005A;
        n = 0;
        while (busy && n < 50) begin n++; step("clear"); end
        chk("clear_busy_cycles", 32'(n), 32'd12);
        idle_ports();
`else
        for (int i = 0; i < DEPTH; i++) begin
            en_a = 1; we_a = 4'hF; a_a = 12'(i * 4); di_a = 0;
            step("fill");
        end
        idle_ports();
`endif
        for (int i = 0; i < DEPTH; i++) begin
            en_b = 1; a_b = 12'(i * 4);
            step("sweep");
            chk($sformatf("sweep_zero_%0d", i), do_b, 32'h0);
        end
        idle_ports();

        add_vec(1, 4'hF, 12'h008, 32'hAABBCCDD, 0, 12'h000, 32'hAABBCCDD, 32'h0);
        add_vec(1, 4'h5, 12'h008, 32'h11223344, 0, 12'h000, 32'hAA22CC44, 32'h0);
        add_vec(1, 4'h0, 12'h00B, 32'hFFFFFFFF, 1, 12'h008, 32'hAA22CC44, 32'hAA22CC44);
        add_vec(1, 4'hF, 12'h00B, 32'h01020304, 0, 12'h000, 32'h01020304, 32'hAA22CC44);
        add_vec(0, 4'hF, 12'h008, 32'h0BADBEEF, 1, 12'h009, 32'h01020304, 32'h01020304);
        add_vec(1, 4'hF, 12'h010, 32'h00000001, 0, 12'h000, 32'h00000001, 32'h01020304);
        add_vec(1, 4'hF, 12'h010, 32'h00000002, 1, 12'h010, 32'h00000002, (RDW_B != 0) ? 32'h2 : 32'h1);
        add_vec(0, 4'h0, 12'h000, 32'h0,        1, 12'h010, 32'h00000002, 32'h00000002);
        add_vec(1, 4'hF, 12'h030, 32'h0000DEAD, 1, 12'h030, 32'h0,        32'h0);
        add_vec(1, 4'h0, 12'h030, 32'h0,        1, 12'h02C, 32'h0,        32'h0);
        add_vec(1, 4'hF, 12'h01C, 32'h00000007, 0, 12'h000, 32'h00000007, 32'h0);
        add_vec(0, 4'h0, 12'h000, 32'h0,        1, 12'h01C, 32'h00000007, 32'h00000007);
        for (int i = 0; i < 4; i++)
            add_vec(0, 4'h0, 12'h000, 32'h0,    0, 12'h000, 32'h00000007, 32'h00000007);
        add_vec(1, 4'h0, 12'h01C, 32'hFFFFFFFF, 0, 12'h000, 32'h00000007, 32'h00000007);
        add_vec(1, 4'hF, 12'hFFC, 32'h0000FFFF, 1, 12'hFFF, 32'h0,        32'h0);

        foreach (tbl[i]) begin
            en_a = tbl[i].en_a; we_a = tbl[i].we; a_a = tbl[i].a_a; di_a = tbl[i].di;
            en_b = tbl[i].en_b; a_b = tbl[i].a_b;
            step("vec");
            chk($sformatf("vec%0d_DoA", i), do_a, tbl[i].xa);
            chk($sformatf("vec%0d_DoB", i), do_b, tbl[i].xb);
        end
        idle_ports();

        for (int i = 0; i < DEPTH; i++) begin
            en_b = 1; a_b = 12'(i * 4);
            step("oor_sweep");
        end
        idle_ports();

        for (int k = 0; k < 400; k++) begin
            en_a = 1'($urandom_range(0, 1));
            we_a = 4'($urandom);
            a_a  = 12'($urandom_range(0, 63));
            di_a = $urandom;
            en_b = 1'($urandom_range(0, 1));
            a_b  = ($urandom_range(0, 3) == 0) ? a_a : 12'($urandom_range(0, 63));
            step("rnd");
        end
        idle_ports();

`ifdef BRAM_DP_CLEAR_EN
        for (int i = 0; i < 5; i++) begin
            en_a = 1; we_a = 4'hF; a_a = 12'(i * 4); di_a = 32'h5A;
            step("pre5A");
        end
        idle_ports();
        rst = 1; step("rst1");
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            en_a = (i == 2); we_a = 4'hF; a_a = 12'h014; di_a = 32'h5A;
            step("midclear");
        end
        idle_ports();
        rst = 1; step("rst2");
        chk("midrst_busy", {31'b0, busy}, 32'h1);
        rst = 0;
        n = 0;
        while (busy && n < 50) begin n++; step("reclear"); end
        chk("reclear_busy_cycles", 32'(n), 32'd12);
        for (int i = 0; i < 6; i++) begin
            en_b = 1; a_b = 12'(i * 4);
            step("after_clear");
            chk($sformatf("cleared_word_%0d", i), do_b, 32'h0);
        end
`else
        rst = 1; step("rst_mid");
        chk("rst_mid_DoA", do_a, 32'h0);
        chk("rst_mid_DoB", do_b, 32'h0);
        rst = 0;
        for (int i = 0; i < DEPTH; i++) begin
            en_a = 1; we_a = 4'h0; a_a = 12'(i * 4); en_b = 1; a_b = 12'(i * 4);
            step("retain");
        end
`endif
        idle_ports();
        step("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
